// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: TX/RX frame queues that feed spi_master back-to-back with a minimum inter-frame gap.
module spi_burst_sequencer #(
    parameter int SLAVE_COUNT = 8,
    parameter int DEPTH = 4,
    parameter int GAP_CYCLES = 2,
    localparam int AW = $clog2(SLAVE_COUNT),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          ext_spi_clkx2,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_len,
    input  logic [31:0]   wr_data,
    output logic          tx_full,
    output logic [LW-1:0] tx_level,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          rx_empty,
    output logic [LW-1:0] rx_level,
    output logic          seq_busy,
    output logic          start_trans,
    output logic [31:0]   tx_data,
    output logic [AW-1:0] chipADDRS,
    output logic [1:0]    transaction_length,
    input  logic          busy,
    input  logic [31:0]   rx_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int EW = AW + 34;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, GAP} state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] tx_mem_q [DEPTH];
    logic [EW-1:0] tx_mem_d [DEPTH];
    logic [31:0]   rx_mem_q [DEPTH];
    logic [31:0]   rx_mem_d [DEPTH];
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [LW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          start_q, start_d;
    logic [31:0]   data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    len_q, len_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_m_q, busy_s_q;
    logic          tx_push, tx_pop, rx_push, rx_pop, rx_full;

    assign tx_full            = tx_cnt_q == LW'(DEPTH);
    assign rx_full            = rx_cnt_q == LW'(DEPTH);
    assign rx_empty           = rx_cnt_q == '0;
    assign tx_level           = tx_cnt_q;
    assign rx_level           = rx_cnt_q;
    assign rd_data            = rx_mem_q[rx_rp_q];
    assign seq_busy           = state_q != IDLE;
    assign start_trans        = start_q;
    assign tx_data            = data_q;
    assign chipADDRS          = addr_q;
    assign transaction_length = len_q;

    always_comb begin
        tx_push  = wr_en && !tx_full;
        tx_pop   = state_q == IDLE && tx_cnt_q != '0 && !rx_full;
        rx_push  = state_q == CAPTURE && !rx_full;
        rx_pop   = rd_en && !rx_empty;
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wp_q] = {wr_addr, wr_len, wr_data};
        if (rx_push) rx_mem_d[rx_wp_q] = rx_data;
        tx_wp_d  = tx_wp_q + PW'(tx_push);
        tx_rp_d  = tx_rp_q + PW'(tx_pop);
        rx_wp_d  = rx_wp_q + PW'(rx_push);
        rx_rp_d  = rx_rp_q + PW'(rx_pop);
        tx_cnt_d = tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
        rx_cnt_d = rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        data_d  = data_q;
        addr_d  = addr_q;
        len_d   = len_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (tx_pop) begin
                {addr_d, len_d, data_d} = tx_mem_q[tx_rp_q];
                start_d = 1'b1;
                state_d = LAUNCH;
            end
            // the master samples start_trans on this clock, so hold it until it acknowledges
            LAUNCH: if (busy_s_q) begin
                start_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: if (!busy_s_q) state_d = CAPTURE;
            CAPTURE: begin
                gap_d   = GW'(GAP_CYCLES);
                state_d = GAP;
            end
            GAP: begin
                gap_d   = gap_q - 1'b1;
                state_d = gap_q <= GW'(1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ext_spi_clkx2 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tx_mem_q <= '{default: '0};
            rx_mem_q <= '{default: '0};
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            busy_m_q <= 1'b0;
            busy_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_mem_q <= tx_mem_d;
            rx_mem_q <= rx_mem_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            start_q  <= start_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            busy_m_q <= busy;
            busy_s_q <= busy_m_q;
        end
    end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb_spi_burst_sequencer: behavioural spi_master stand-in plus frame/RX scoreboards around the sequencer.
module tb_spi_burst_sequencer;
    localparam int DEPTH = 4;
    localparam int GAP_CYCLES = 2;

    typedef struct packed {
        logic [2:0]  addr;
        logic [1:0]  len;
        logic [31:0] data;
    } frame_t;

    typedef struct {
        logic [2:0]  addr;
        logic [1:0]  len;
        logic [31:0] data;
        bit          acc;
        bit          rd;
        logic        exp_full;
        logic [2:0]  exp_lvl;
    } vec_t;

    logic        clk = 0, rst = 1;
    logic        wr_en = 0, rd_en = 0, busy = 0;
    logic [2:0]  wr_addr = 0;
    logic [1:0]  wr_len = 0;
    logic [31:0] wr_data = 0, rx_data = 0;
    logic        tx_full, rx_empty, seq_busy, start_trans;
    logic [2:0]  tx_level, rx_level, chipADDRS;
    logic [31:0] rd_data, tx_data;
    logic [1:0]  transaction_length;

    int     n_vec = 0, n_err = 0, n_launch = 0;
    bit     master_en = 0;
    frame_t lq[$];
    logic [31:0] rxq[$];
    vec_t   tbl[5];

    spi_burst_sequencer #(.SLAVE_COUNT(8), .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .ext_spi_clkx2(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_data(wr_data), .tx_full(tx_full), .tx_level(tx_level), .rd_en(rd_en), .rd_data(rd_data),
        .rx_empty(rx_empty), .rx_level(rx_level), .seq_busy(seq_busy), .start_trans(start_trans),
        .tx_data(tx_data), .chipADDRS(chipADDRS), .transaction_length(transaction_length),
        .busy(busy), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lmask(input logic [1:0] l);
        return l == 2'd0 ? 32'h0000_00FF : l == 2'd1 ? 32'h0000_FFFF : l == 2'd2 ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic [1:0] l, input logic [31:0] d, input bit acc, input bit pop);
        wr_addr = a;
        wr_len  = l;
        wr_data = d;
        wr_en   = 1;
        rd_en   = pop;
        if (acc) begin
            lq.push_back(frame_t'({a, l, d}));
            rxq.push_back(d & lmask(l));
        end
        @(posedge clk); #1;
        wr_en = 0;
        rd_en = 0;
    endtask

    task automatic wait_rx(input int lvl, input string nm);
        for (int i = 0; i < 400 && rx_level != 3'(lvl); i++) begin @(posedge clk); #1; end
        check(nm, rx_level, lvl);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 400 && seq_busy; i++) begin @(posedge clk); #1; end
        check(nm, seq_busy, 0);
    endtask

    task automatic pop_rx(input string nm);
        logic [31:0] exp;
        for (int i = 0; i < 400 && rx_empty; i++) begin @(posedge clk); #1; end
        exp = rxq.size() > 0 ? rxq.pop_front() : 32'hxxxx_xxxx;
        check(nm, rd_data, exp);
        rd_en = 1;
        @(posedge clk); #1;
        rd_en = 0;
    endtask

    // spi_master stand-in: loops MOSI back to MISO, frame length scales with transaction_length
    initial begin
        logic [31:0] dat;
        logic [1:0]  ln;
        forever begin
            @(posedge clk); #1;
            if (rst) busy = 0;
            else if (master_en && start_trans && !busy) begin
                dat  = tx_data;
                ln   = transaction_length;
                busy = 1;
                for (int i = 0; i < 4 + 2 * int'(ln) && !rst; i++) begin @(posedge clk); #1; end
                if (!rst) rx_data = dat & lmask(ln);
                busy = 0;
            end
        end
    end

    initial begin
        bit st_prev = 0, bz_prev = 0, have_fall = 0;
        int since = 0;
        forever begin
            @(posedge clk); #2;
            since++;
            if (rst) begin
                have_fall = 0;
                st_prev   = 0;
                bz_prev   = busy;
            end else begin
                if (bz_prev && !busy) begin
                    since     = 0;
                    have_fall = 1;
                end
                if (start_trans && !st_prev) begin
                    n_launch++;
                    if (lq.size() == 0) check("launch_unexpected", 1, 0);
                    else check("launch_frame", {chipADDRS, transaction_length, tx_data}, lq.pop_front());
                    if (have_fall) check("frame_gap", since >= GAP_CYCLES + 5, 1);
                end
                if (st_prev && !start_trans) check("start_held_until_busy", busy, 1);
                st_prev = start_trans;
                bz_prev = busy;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int nl;
        tbl[0] = '{3'd0, 2'd0, 32'h0000_0011, 1, 0, 1'b0, 3'd1};
        tbl[1] = '{3'd2, 2'd1, 32'h0000_2233, 1, 0, 1'b0, 3'd2};
        tbl[2] = '{3'd4, 2'd2, 32'h0044_5566, 1, 0, 1'b0, 3'd3};
        tbl[3] = '{3'd7, 2'd3, 32'h8899_AABB, 1, 0, 1'b1, 3'd4};
        tbl[4] = '{3'd6, 2'd1, 32'h0000_DEAD, 0, 1, 1'b1, 3'd4};

        repeat (3) @(posedge clk); #1;
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_level", rx_level, 0);
        check("rst_start", start_trans, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_addr", chipADDRS, 0);
        check("rst_len", transaction_length, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_seq_busy", seq_busy, 0);
        rst = 0;
        @(posedge clk); #1;

        master_en = 1;
        push(3'd3, 2'd0, 32'h0000_00A5, 1, 0);
        check("t1_start_after_push", start_trans, 0);
        check("t1_tx_level_push", tx_level, 1);
        @(posedge clk); #1;
        check("t1_start_latency", start_trans, 1);
        check("t1_addr", chipADDRS, 3);
        check("t1_len", transaction_length, 0);
        check("t1_tx_level_pop", tx_level, 0);
        wait_rx(1, "t1_rx_level");
        pop_rx("t1_rd_data");
        check("t1_rx_empty", rx_empty, 1);
        wait_idle("t1_idle");

        master_en = 0;
        push(3'd1, 2'd2, 32'h00AB_CDEF, 1, 0);
        repeat (10) @(posedge clk); #1;
        check("t6_start_held", start_trans, 1);
        check("t6_seq_busy", seq_busy, 1);
        check("t6_no_rx", rx_level, 0);
        check("t6_tx_level", tx_level, 0);
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].addr, tbl[i].len, tbl[i].data, tbl[i].acc, tbl[i].rd);
            check($sformatf("tbl%0d_tx_full", i), tx_full, tbl[i].exp_full);
            check($sformatf("tbl%0d_tx_level", i), tx_level, tbl[i].exp_lvl);
            check($sformatf("tbl%0d_rx_level", i), rx_level, 0);
        end
        check("t6_start_still_held", start_trans, 1);

        master_en = 1;
        wait_rx(DEPTH, "t3_rx_fill");
        nl = n_launch;
        repeat (20) @(posedge clk); #1;
        check("t3_no_launch_when_rx_full", n_launch, nl);
        check("t3_tx_stalled", tx_level, 1);
        check("t3_idle_stalled", seq_busy, 0);
        pop_rx("t3_pop_head");
        for (int i = 0; i < 50 && n_launch == nl; i++) begin @(posedge clk); #1; end
        check("t3_fifth_launch", n_launch, nl + 1);
        wait_rx(DEPTH, "t3_rx_refill");
        for (int i = 0; i < DEPTH; i++) pop_rx($sformatf("t2_rx_order%0d", i));
        check("t2_rx_drained", rx_empty, 1);
        check("t2_tx_drained", tx_level, 0);
        wait_idle("t2_idle");

        push(3'd5, 2'd3, 32'hDEAD_BEEF, 1, 0);
        for (int i = 0; i < 50 && !busy; i++) begin @(posedge clk); #1; end
        check("t5_busy_seen", busy, 1);
        repeat (4) @(posedge clk); #1;
        check("t5_in_wait_start", start_trans, 0);
        check("t5_in_wait_busy", seq_busy, 1);
        #2 rst = 1;
        #1;
        check("t5_rst_start", start_trans, 0);
        check("t5_rst_seq_busy", seq_busy, 0);
        check("t5_rst_tx_level", tx_level, 0);
        check("t5_rst_rx_level", rx_level, 0);
        check("t5_rst_rx_empty", rx_empty, 1);
        check("t5_rst_tx_data", tx_data, 0);
        rxq.delete();
        repeat (2) @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        push(3'd2, 2'd1, 32'h0000_1234, 1, 0);
        wait_rx(1, "t5_post_rx_level");
        pop_rx("t5_post_rd_data");
        wait_idle("t5_idle");
        check("sb_launch_drained", lq.size(), 0);
        check("sb_rx_drained", rxq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
